// File: rtl/mips_pkg.sv
// Shared MIPS definitions: the sequencer state encoding (also used by the
// control decoder), the opcode/function constants the sequencer inspects,
// and the MULT/DIV classifier.
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH         = 3'b000,
        S_DECODE        = 3'b001,
        S_EXECUTE       = 3'b010,
        S_MEMORY_ACCESS = 3'b011,
        S_WRITE_BACK    = 3'b100,
        S_HALTED        = 3'b101
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // Width of the EXECUTE hold counter; MULDIV_CYCLES must fit in it.
    localparam int MD_CNT_W = 4;

    // True for the R-type instructions that occupy the multi-cycle divider/multiplier.
    function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) &&
               ((fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU));
    endfunction

endpackage

// File: rtl/muldiv_hold_counter.sv
// Down-counter that holds the sequencer in EXECUTE for multi-cycle MULT/DIV.
// Loaded with (cycles - 1) on entry to EXECUTE; busy while non-zero, done at 0.
module muldiv_hold_counter
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [MD_CNT_W-1:0] i_load_value,
    output logic                o_busy,
    output logic                o_done
);

    logic [MD_CNT_W-1:0] r_count;

    // Load on request, otherwise count down to zero and stay there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_busy = (r_count != '0);
    assign o_done = (r_count == '0);

endmodule

// File: rtl/mips_state_sequencer.sv
// Multi-cycle MIPS sequencer: FETCH -> DECODE -> EXECUTE -> MEMORY_ACCESS
// (-> WRITE_BACK), with Avalon waitrequest stalls in memory states, a hold in
// EXECUTE for MULT/DIV, and a halt when the instruction leaves PC == 0.
module mips_state_sequencer
    import mips_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4   // legal range 1..15
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func_code,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        waitrequest,
    input  logic [31:0] pc_next,
    output logic [2:0]  state,
    output logic        active,
    output logic        retire,
    output logic        muldiv_busy
);

    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MULDIV_CYCLES - 1);

    state_t r_state;
    logic   r_active;

    logic   w_mem_state;
    logic   w_mem_stall;
    logic   w_final;
    state_t w_end_state;
    logic   w_md_load;
    logic   w_md_busy;
    logic   w_md_done;

    // waitrequest only matters in the two states that own the memory bus.
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMORY_ACCESS);
    assign w_mem_stall = w_mem_state && (mem_read || mem_write) && waitrequest;

    // Final cycle of an instruction: MEMORY_ACCESS advancing for non-LW, or WRITE_BACK.
    // Combinational so that a stalled MEMORY_ACCESS never shows a retire.
    assign w_final = ((r_state == S_MEMORY_ACCESS) && !w_mem_stall && (opcode != OP_LW)) ||
                     (r_state == S_WRITE_BACK);

    // Where an instruction goes when it ends; pc_next only matters on the advancing edge.
    assign w_end_state = (pc_next == 32'h0) ? S_HALTED : S_FETCH;

    // The counter is loaded on the DECODE -> EXECUTE edge; for non-MULT/DIV it stays 0.
    assign w_md_load = (r_state == S_DECODE) && is_muldiv(opcode, func_code);

    muldiv_hold_counter u_hold (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_md_load),
        .i_load_value (MD_LOAD),
        .o_busy       (w_md_busy),
        .o_done       (w_md_done)
    );

    // Sequencer state and the registered active flag, which falls together with HALTED.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_active <= 1'b1;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!w_mem_stall) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (w_md_done) r_state <= S_MEMORY_ACCESS;
                end
                S_MEMORY_ACCESS: begin
                    if (!w_mem_stall) begin
                        if (opcode == OP_LW) begin
                            r_state <= S_WRITE_BACK;
                        end else begin
                            r_state  <= w_end_state;
                            r_active <= (w_end_state != S_HALTED);
                        end
                    end
                end
                S_WRITE_BACK: begin
                    r_state  <= w_end_state;
                    r_active <= (w_end_state != S_HALTED);
                end
                S_HALTED: begin
                    r_state  <= S_HALTED;
                    r_active <= 1'b0;
                end
                default: begin
                    // Unused encodings fall into the absorbing halt.
                    r_state  <= S_HALTED;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign active      = r_active;
    assign retire      = w_final;
    assign muldiv_busy = w_md_busy;

endmodule
